// File: rtl/lsu_mem_master.sv
// Load/store unit bridging the core execute stage to a word-wide, byte-strobed data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of splitting them.
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b01:   n = 3'd4;
            2'b10:   n = 3'd2;
            2'b11:   n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic spans_word(input logic [1:0] off, input logic [1:0] size);
        return (({1'b0, off} + size_bytes(size)) > 3'd4);
    endfunction

    // Beat 1 carries whatever spilled past lane 3 on beat 0.
    function automatic logic [3:0] strb_lanes(input logic [1:0] off, input logic [1:0] size,
                                              input logic beat);
        logic [7:0] full;
        full = ((8'd1 << size_bytes(size)) - 8'd1) << off;
        return beat ? full[7:4] : full[3:0];
    endfunction

    function automatic logic [31:0] wdata_lanes(input logic [1:0] off, input logic [31:0] data,
                                                input logic beat);
        logic [63:0] full;
        full = {32'd0, data} << {off, 3'b000};
        return beat ? full[63:32] : full[31:0];
    endfunction

    function automatic logic [31:0] lane_extract(input logic [63:0] d, input logic [1:0] off);
        logic [31:0] r;
        case (off)
            2'd0:    r = d[31:0];
            2'd1:    r = d[39:8];
            2'd2:    r = d[47:16];
            2'd3:    r = d[55:24];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] raw);
        logic [31:0] r;
        case (size)
            2'b10:   r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            2'b11:   r = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic               beat_r, beat_s;
    logic               wr_r, wr_s;
    logic [1:0]         size_r, size_s;
    logic               sgn_r, sgn_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [31:0]        wdata_r, wdata_s;
    logic [31:0]        rbuf_r, rbuf_s;
    logic               req_ready_r, req_ready_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [31:0]        rsp_rdata_r, rsp_rdata_s;
    logic               rsp_err_r, rsp_err_s;
    logic               mem_valid_r, mem_valid_s;
    logic               mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
    logic [3:0]         mem_wstrb_r, mem_wstrb_s;
    logic [31:0]        mem_wdata_r, mem_wdata_s;

    logic               trap_s;
    logic               in_err_s;
    logic               split_s;
    logic [ADDR_W-1:0]  next_word_s;
    logic [63:0]        rd64_s;
    logic [31:0]        ld_data_s;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s = ((req_size == 2'b10) && req_addr[0]) ||
                    ((req_size == 2'b01) && (req_addr[1:0] != 2'b00));
`else
    assign trap_s = 1'b0;
`endif

    assign in_err_s    = (req_size == 2'b00) || trap_s;
    assign split_s     = spans_word(addr_r[1:0], size_r);
    assign next_word_s = {addr_r[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign rd64_s      = beat_r ? {mem_rdata, rbuf_r} : {32'd0, mem_rdata};
    assign ld_data_s   = load_ext(size_r, sgn_r, lane_extract(rd64_s, addr_r[1:0]));

    // Next-state and next-output computation for the request/bus/response sequencer.
    always_comb begin
        state_s     = state_r;
        beat_s      = beat_r;
        wr_s        = wr_r;
        size_s      = size_r;
        sgn_s       = sgn_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        rbuf_s      = rbuf_r;
        req_ready_s = req_ready_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        mem_valid_s = mem_valid_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wstrb_s = mem_wstrb_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid && req_ready_r) begin
                    req_ready_s = 1'b0;
                    wr_s        = req_wr;
                    size_s      = req_size;
                    sgn_s       = req_signed;
                    addr_s      = req_addr;
                    wdata_s     = req_wdata;
                    beat_s      = 1'b0;
                    if (in_err_s) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = 32'd0;
                    end else begin
                        state_s     = ST_ISSUE;
                        mem_valid_s = 1'b1;
                        mem_we_s    = req_wr;
                        mem_addr_s  = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_wr) begin
                            mem_wstrb_s = strb_lanes(req_addr[1:0], req_size, 1'b0);
                            mem_wdata_s = wdata_lanes(req_addr[1:0], req_wdata, 1'b0);
                        end else begin
                            mem_wstrb_s = 4'd0;
                            mem_wdata_s = 32'd0;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    mem_valid_s = 1'b0;
                    if (wr_r && split_s && !beat_r) begin
                        beat_s      = 1'b1;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = next_word_s;
                        mem_wstrb_s = strb_lanes(addr_r[1:0], size_r, 1'b1);
                        mem_wdata_s = wdata_lanes(addr_r[1:0], wdata_r, 1'b1);
                    end else if (wr_r) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b0;
                        rsp_rdata_s = 32'd0;
                    end else begin
                        state_s = ST_WAIT_R;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    if (split_s && !beat_r) begin
                        rbuf_s      = mem_rdata;
                        beat_s      = 1'b1;
                        state_s     = ST_ISSUE;
                        mem_valid_s = 1'b1;
                        mem_we_s    = 1'b0;
                        mem_addr_s  = next_word_s;
                        mem_wstrb_s = 4'd0;
                        mem_wdata_s = 32'd0;
                    end else begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b0;
                        rsp_rdata_s = ld_data_s;
                    end
                end else begin
                    state_s = ST_WAIT_R;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    req_ready_s = 1'b1;
                    rsp_valid_s = 1'b0;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = 32'd0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
                mem_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            beat_r      <= 1'b0;
            wr_r        <= 1'b0;
            size_r      <= 2'b00;
            sgn_r       <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'd0;
            rbuf_r      <= 32'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wstrb_r <= 4'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            beat_r      <= beat_s;
            wr_r        <= wr_s;
            size_r      <= size_s;
            sgn_r       <= sgn_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            rbuf_r      <= rbuf_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            mem_valid_r <= mem_valid_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wstrb_r <= mem_wstrb_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_valid = mem_valid_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wstrb = mem_wstrb_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table plus hand-written stall, split and reset sequences.
// Expected values for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        suppress_rv = 1'b0;
    logic        inject_rv = 1'b0;
    logic [31:0] mem [0:15];
    int          acc_total = 0;
    logic [31:0] log_addr [0:7];
    logic [3:0]  log_strb [0:7];
    logic [31:0] log_wdata [0:7];

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Zero-wait memory: applies strobed writes, returns read data the cycle after acceptance.
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_valid && mem_ready) begin
            log_addr[acc_total[2:0]]  <= mem_addr;
            log_strb[acc_total[2:0]]  <= mem_wstrb;
            log_wdata[acc_total[2:0]] <= mem_wdata;
            acc_total <= acc_total + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else if (!suppress_rv) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[mem_addr[5:2]];
            end
        end
        if (inject_rv) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= 32'hA5A5A5A5;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // One request with rsp_ready held high; latency counts cycles from acceptance to rsp_valid.
    task automatic do_txn(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int beats, output int base);
        wait_ready();
        req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        base = acc_total;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        beats = acc_total - base;
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          beats;
        logic [3:0]  strb;
        logic [31:0] mwdata;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] rd;
    logic        er;
    int          lat, beats, base;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'b01, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 4'hF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[2]  = '{1'b1, 2'b11, 1'b0, 32'h13, 32'h12345680, 32'h0,        1'b0, 2, 1, 4'h8, 32'h80000000};
        vecs[3]  = '{1'b0, 2'b11, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h12, 32'h00001234, 32'h0,        1'b0, 2, 1, 4'hC, 32'h12340000};
        vecs[6]  = '{1'b0, 2'b10, 1'b1, 32'h12, 32'h0,        32'h00001234, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 3, 1, 4'h0, 32'h0};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h20, 32'hCCBBAA00, 32'h0,        1'b0, 2, 1, 4'hF, 32'hCCBBAA00};
        vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h24, 32'h000000DD, 32'h0,        1'b0, 2, 1, 4'hF, 32'h000000DD};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h15, 32'h000000EE, 32'h0,        1'b0, 2, 1, 4'h2, 32'h0000EE00};
        vecs[16] = '{1'b0, 2'b11, 1'b0, 32'h15, 32'h0,        32'h000000EE, 1'b0, 3, 1, 4'h0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        chk("rst_mem_ctl", {mem_valid, mem_we, mem_wstrb}, 64'd0);
        chk("rst_mem_data", {mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 17; i++) begin
            do_txn(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, beats, base);
            chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
            chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].err));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_beats", i), 64'(beats), 64'(vecs[i].beats));
            if (vecs[i].beats > 0) begin
                chk($sformatf("v%0d_maddr", i), 64'(log_addr[base % 8]),
                    64'({vecs[i].addr[31:2], 2'b00}));
                chk($sformatf("v%0d_strb", i), 64'(log_strb[base % 8]), 64'(vecs[i].strb));
                chk($sformatf("v%0d_mwdata", i), 64'(log_wdata[base % 8]), 64'(vecs[i].mwdata));
            end
        end

        // Misaligned accesses: split across words, or trapped.
        do_txn(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, rd, er, lat, beats, base);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("wl21_rdata", 64'(rd), 64'h0);
        chk("wl21_err", 64'(er), 64'd1);
        chk("wl21_lat", 64'(lat), 64'd1);
        chk("wl21_beats", 64'(beats), 64'd0);
`else
        chk("wl21_rdata", 64'(rd), 64'hDDCCBBAA);
        chk("wl21_err", 64'(er), 64'd0);
        chk("wl21_lat", 64'(lat), 64'd5);
        chk("wl21_beats", 64'(beats), 64'd2);
        chk("wl21_addr0", 64'(log_addr[base % 8]), 64'h20);
        chk("wl21_addr1", 64'(log_addr[(base + 1) % 8]), 64'h24);
`endif
        do_txn(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rd, er, lat, beats, base);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("hl11_err", {er, rd}, {1'b1, 32'h0});
        chk("hl11_beats", 64'(beats), 64'd0);
`else
        chk("hl11_rdata", {er, rd}, {1'b0, 32'h000034BE});
        chk("hl11_lat", 64'(lat), 64'd3);
`endif
        do_txn(1'b1, 2'b10, 1'b0, 32'h23, 32'h0000ABCD, rd, er, lat, beats, base);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("hs23_err", {er, rd}, {1'b1, 32'h0});
        chk("hs23_lat", 64'(lat), 64'd1);
        chk("hs23_beats", 64'(beats), 64'd0);
`else
        chk("hs23_err", {er, rd}, {1'b0, 32'h0});
        chk("hs23_lat", 64'(lat), 64'd3);
        chk("hs23_beats", 64'(beats), 64'd2);
        chk("hs23_beat0", {log_addr[base % 8], log_strb[base % 8], log_wdata[base % 8]},
            {32'h20, 4'h8, 32'hCD000000});
        chk("hs23_beat1", {log_addr[(base + 1) % 8], log_strb[(base + 1) % 8],
            log_wdata[(base + 1) % 8]}, {32'h24, 4'h1, 32'h000000AB});
`endif
        do_txn(1'b0, 2'b01, 1'b0, 32'h24, 32'h0, rd, er, lat, beats, base);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("after_hs23_w24", 64'(rd), 64'h000000DD);
`else
        chk("after_hs23_w24", 64'(rd), 64'h000000AB);
`endif
        do_txn(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er, lat, beats, base);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("after_hs23_w20", 64'(rd), 64'hCCBBAA00);
`else
        chk("after_hs23_w20", 64'(rd), 64'hCDBBAA00);
`endif

        // Bus stall of 3 cycles and response back-pressure of 2 cycles.
        mem_ready = 1'b0;
        rsp_ready = 1'b0;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_bus", c), {mem_valid, mem_we, mem_wstrb, mem_addr[7:0], req_ready},
                {1'b1, 1'b1, 4'hF, 8'h30, 1'b0});
            chk($sformatf("stall%0d_wdata", c), 64'(mem_wdata), 64'h11223344);
            if (c == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_rsp", c), {rsp_valid, rsp_err, rsp_rdata, req_ready, mem_valid},
                {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
            if (c == 2) rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_done", {rsp_valid, req_ready}, {1'b0, 1'b1});
        do_txn(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, rd, er, lat, beats, base);
        chk("stall_store_readback", 64'(rd), 64'h11223344);

        // Reset while waiting for read data; a late rvalid must not produce a response.
        suppress_rv = 1'b1;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b01; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", {mem_valid, rsp_valid, req_ready}, 64'd0);
        rst = 1'b0;
        suppress_rv = 1'b0;
        inject_rv = 1'b1;
        @(negedge clk);
        inject_rv = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                if (rsp_valid) seen++;
                @(negedge clk);
            end
            chk("late_rvalid_no_rsp", 64'(seen), 64'd0);
        end
        do_txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat, beats, base);
        chk("post_rst_rdata", 64'(rd), 64'h1234BEEF);
        chk("post_rst_lat", 64'(lat), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
